// File: rtl/rv_wb_arbiter.sv
// rv_wb_arbiter: shares the register-file write port between N_REQ writeback
// sources with round-robin arbitration, registers the winning write, and
// keeps a pending-write scoreboard used by decode for RAW hazard stalls.
module rv_wb_arbiter #(
  parameter int N_REQ      = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_rd,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [ADDR_WIDTH-1:0]         rf_rd,
  output logic [DATA_WIDTH-1:0]         rf_wd,
  output logic                          rf_we,
  input  logic                          iss_valid,
  input  logic [ADDR_WIDTH-1:0]         iss_rd,
  input  logic [ADDR_WIDTH-1:0]         chk_rs1,
  input  logic [ADDR_WIDTH-1:0]         chk_rs2,
  output logic                          rs1_busy,
  output logic                          rs2_busy
);

  localparam int PTR_W    = $clog2(N_REQ);
  localparam int NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [PTR_W:0]   N_REQ_W = (PTR_W+1)'(N_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_found;
  logic                  transfer;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path through the block leaves a value unassigned (no latch).
    sum         = '0;
    idx         = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= N_REQ_W) sum = sum - N_REQ_W;
      idx = sum[PTR_W-1:0];
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  // One-hot ready for the winner; also select its destination and data.
  always_comb begin
    req_ready = '0;
    sel_rd    = '0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        req_ready[i] = grant_found;
        sel_rd       = req_rd[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Grants are visible during reset, but nothing is committed until it drops.
  assign transfer = grant_found & ~rst;

  // Round-robin pointer: moves just past the winner on each transfer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block order.
    if (rst) begin
      rr_ptr <= '0;
    end else if (transfer) begin
      rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  // Registered write port; x0 writes are accepted but never enable the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wd <= '0;
    end else if (transfer) begin
      rf_we <= (sel_rd != '0);
      rf_rd <= sel_rd;
      rf_wd <= sel_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // Scoreboard update: clear on committed write, then set on issue so a newer
  // instruction keeps ownership of a register written in the same cycle.
  always_comb begin
    busy_next = busy;
    if (rf_we) busy_next[rf_rd] = 1'b0;
    if (iss_valid && (iss_rd != '0)) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  assign rs1_busy = busy[chk_rs1];
  assign rs2_busy = busy[chk_rs2];

endmodule

// File: doc/rv_wb_arbiter.md
Name: rv_wb_arbiter

Overview:
- Shares the single write port of the 32x32 RISC-V register file between N_REQ writeback sources, e.g. ALU, load unit and multicycle mul/div.
- Arbitration is round-robin with a valid/ready handshake; the winning write is registered onto the register-file write port.
- Keeps a 32-bit pending-write scoreboard: issue sets a bit, the committed write clears it. Decode uses it to stall on RAW hazards.

Parameters:
- N_REQ, 3, number of writeback requesters (2..8).
- ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 32, register data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  per-requester write request.
- req_ready  output  N_REQ  per-requester grant; one-hot or zero.
- req_rd  input  N_REQ*ADDR_WIDTH  destination register per requester; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  input  N_REQ*DATA_WIDTH  write data per requester; same slicing.
- rf_rd  output  ADDR_WIDTH  register-file write address.
- rf_wd  output  DATA_WIDTH  register-file write data.
- rf_we  output  1  register-file write enable.
- iss_valid  input  1  an instruction with a destination register issues this cycle.
- iss_rd  input  ADDR_WIDTH  destination of the issuing instruction.
- chk_rs1  input  ADDR_WIDTH  source 1 to check.
- chk_rs2  input  ADDR_WIDTH  source 2 to check.
- rs1_busy  output  1  chk_rs1 has a pending write.
- rs2_busy  output  1  chk_rs2 has a pending write.

Behaviour:
- Reset: rf_we=0, rf_rd=0, rf_wd=0, rr_ptr=0, all busy bits 0. req_ready follows req_valid combinationally even during reset, but no transfer is committed while rst=1.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo N_REQ.
  - The first valid index g gets req_ready[g]=1; all other ready bits are 0.
  - No valid requester gives req_ready=0.
- Transfer = req_valid[g] & req_ready[g]. At most one transfer per cycle.
- Pointer:
  - On a transfer, rr_ptr <= (g+1) mod N_REQ.
  - Otherwise rr_ptr holds.
  - A continuously valid requester therefore waits at most N_REQ-1 cycles.
- Write port (registered, 1-cycle latency):
  - On a transfer: rf_rd <= req_rd[g], rf_wd <= req_data[g], rf_we <= (req_rd[g] != 0).
  - With no transfer: rf_we <= 0; rf_rd and rf_wd hold their last values.
  - A write to x0 is accepted (ready asserted, pointer advances) but never drives rf_we.
- Requester contract: once valid, a requester holds rd/data stable until ready. The arbiter does not check this.
- Scoreboard busy[31:0], where busy[0] is constant 0:
  - Set: iss_valid & (iss_rd != 0) sets busy[iss_rd] at the clock edge.
  - Clear: rf_we=1 clears busy[rf_rd] at the same edge the register file captures the write.
  - Simultaneous set and clear of the same register: set wins, because the newer instruction owns the register.
  - A set and a clear of different registers both take effect.
  - Clearing a non-busy register is harmless.
- Busy outputs: rs1_busy = busy[chk_rs1] and rs2_busy = busy[chk_rs2], combinational from current state. There is no bypass of same-cycle set or clear.
- Timing summary:
  - Cycle N: transfer.
  - Cycle N+1: rf_we high; clears busy at the end of N+1.
  - Cycle N+2: busy reads 0.
- Reset mid-operation: pending grants are dropped, the scoreboard is cleared, and the register-file write in flight at the reset edge is suppressed (rf_we=0 after the edge).

Test Plan:
- Reset, then idle cycles:
  - rf_we=0, req_ready=000.
  - rs1_busy=rs2_busy=0 for chk_rs1=1, chk_rs2=31.
- Single write: req_valid=001, req_rd[0]=4, data 0x77.
  - Same cycle: req_ready=001.
  - Next cycle: rf_we=1, rf_rd=4, rf_wd=0x77.
  - Following cycle: rf_we=0.
- All three valid continuously (rd 1/2/3, data 0xA/0xB/0xC) for 6 cycles:
  - Grants in order 0,1,2,0,1,2.
  - rf_wd sequence 0xA,0xB,0xC,0xA,0xB,0xC, each one cycle after its grant.
- x0 write: req_rd[1]=0, data 0x55, valid.
  - req_ready[1]=1, rf_we stays 0, rr_ptr advances to 2.
- Scoreboard, set then clear:
  - Issue rd=5; next cycle rs1_busy=1 with chk_rs1=5.
  - Requester 2 writes rd=5: busy until the end of the rf_we cycle, 0 the cycle after.
  - iss_rd=0 never sets busy.
- Set/clear collision and reset:
  - iss_valid with iss_rd=7 in the same cycle rf_we=1, rf_rd=7: busy[7] stays 1.
  - Then assert rst for one cycle with busy bits 3, 7 set and a transfer pending: after rst, all busy=0, rf_we=0, rr_ptr=0.
